// File: rtl/ex_mem_stage.sv
// ============================================================================
//  Module   : ex_mem_stage
//  Purpose  : Registered EX->MEM pipeline boundary behind the 64-bit ALU.
//             Holds up to two entries (head + skid) so that ex_ready can be
//             a pure register output. Resolves B/CBZ/CBNZ into a one-cycle
//             PC redirect pulse and drops the wrong-path instruction that is
//             accepted while that pulse is high.
//  Ports    : clk, rst_n (sync, active-low)
//             ex_*      : execute-side valid/ready handshake and entry fields
//             mem_*     : memory-side valid/ready handshake and head fields
//             flush     : discard held and incoming entries
//             redirect_*: taken-branch redirect pulse and target
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // execute side
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_br_uncond,
    input  logic              ex_br_zero,
    input  logic              ex_br_nzero,
    input  logic              flush,
    // memory side
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_reg_write,
    output logic              mem_mem_to_reg,
    // branch redirect
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc
);

    // Entry layout: {alu result, store data, rd, mem_read, mem_write,
    //                reg_write, mem_to_reg}
    localparam int C_ENTRY_W = 2*DATA_W + REG_W + 4;
    localparam int C_RD_LSB  = 4;
    localparam int C_SD_LSB  = C_RD_LSB + REG_W;
    localparam int C_AR_LSB  = C_SD_LSB + DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_ENTRY_W-1:0]  r_head;
    logic [C_ENTRY_W-1:0]  r_skid;
    logic [C_ENTRY_W-1:0]  w_head_nxt;
    logic [C_ENTRY_W-1:0]  w_skid_nxt;
    logic [C_ENTRY_W-1:0]  w_in_entry;
    logic                  r_ex_ready;
    logic                  r_redirect_valid;
    logic [DATA_W-1:0]     r_redirect_pc;

    logic w_accept;
    logic w_drain;
    logic w_store;
    logic w_taken;
    logic w_redirect_nxt;

    assign w_in_entry = {alu_out, ex_store_data, ex_rd,
                         ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg};

    assign w_accept = ex_valid & r_ex_ready;
    assign w_drain  = (r_state != S_EMPTY) & mem_ready;

    // The instruction accepted while a redirect pulse is high is on the
    // wrong path: it is consumed by the handshake but never stored.
    assign w_store  = w_accept & ~r_redirect_valid;

    assign w_taken  = ex_br_uncond
                    | (ex_br_zero  &  alu_zero)
                    | (ex_br_nzero & ~alu_zero);

    // A flush kills the incoming branch, so it cannot redirect either.
    assign w_redirect_nxt = w_store & w_taken & ~flush;

    // ------------------------------------------------------------------
    // Occupancy next-state and head/skid selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Clearing the head keeps discarded controls off mem_*.
            w_state_nxt = S_EMPTY;
            w_head_nxt  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_store) begin
                        w_state_nxt = S_ONE;
                        w_head_nxt  = w_in_entry;
                    end
                end
                S_ONE: begin
                    if (w_store && w_drain) begin
                        w_head_nxt  = w_in_entry;
                    end else if (w_store) begin
                        w_state_nxt = S_TWO;
                        w_skid_nxt  = w_in_entry;
                    end else if (w_drain) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // ex_ready is low here, so only a drain can happen.
                    if (w_drain) begin
                        w_state_nxt = S_ONE;
                        w_head_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= S_EMPTY;
            r_head           <= '0;
            r_skid           <= '0;
            r_ex_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_head           <= w_head_nxt;
            r_skid           <= w_skid_nxt;
            // Registered ready: look ahead at next occupancy.
            r_ex_ready       <= (w_state_nxt != S_TWO);
            r_redirect_valid <= w_redirect_nxt;
            if (w_redirect_nxt) begin
                r_redirect_pc <= ex_branch_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_ready        = r_ex_ready;
    assign mem_valid       = (r_state != S_EMPTY);
    assign mem_addr_result = r_head[C_AR_LSB +: DATA_W];
    assign mem_store_data  = r_head[C_SD_LSB +: DATA_W];
    assign mem_rd          = r_head[C_RD_LSB +: REG_W];
    assign mem_mem_read    = r_head[3];
    assign mem_mem_write   = r_head[2];
    assign mem_reg_write   = r_head[1];
    assign mem_mem_to_reg  = r_head[0];
    assign redirect_valid  = r_redirect_valid;
    assign redirect_pc     = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Purpose  : Self-checking bench for ex_mem_stage. Entries expected to reach
//             the memory side are queued when driven and compared in order
//             when the memory side takes them. A vector table covers branch
//             resolution and wrong-path drop; hand-written sequences cover
//             reset, back-pressure, flush and reset while full.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] alu_out;
    logic          alu_zero;
    logic [DW-1:0] ex_store_data;
    logic [DW-1:0] ex_branch_target;
    logic [RW-1:0] ex_rd;
    logic          ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic          ex_br_uncond, ex_br_zero, ex_br_nzero;
    logic          flush;
    logic          mem_valid;
    logic          mem_ready;
    logic [DW-1:0] mem_addr_result;
    logic [DW-1:0] mem_store_data;
    logic [RW-1:0] mem_rd;
    logic          mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .alu_out          (alu_out),
        .alu_zero         (alu_zero),
        .ex_store_data    (ex_store_data),
        .ex_branch_target (ex_branch_target),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_br_uncond     (ex_br_uncond),
        .ex_br_zero       (ex_br_zero),
        .ex_br_nzero      (ex_br_nzero),
        .flush            (flush),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_addr_result  (mem_addr_result),
        .mem_store_data   (mem_store_data),
        .mem_rd           (mem_rd),
        .mem_mem_read     (mem_mem_read),
        .mem_mem_write    (mem_mem_write),
        .mem_reg_write    (mem_reg_write),
        .mem_mem_to_reg   (mem_mem_to_reg),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [DW-1:0] sdata;
        logic [RW-1:0] rd;
        logic [3:0]    ctl;   // {mem_read, mem_write, reg_write, mem_to_reg}
    } exp_t;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] sdata;
        logic [RW-1:0] rd;
        logic [3:0]    ctl;
        logic [2:0]    br;    // {uncond, zero, nzero}
        logic          zero;
        logic [DW-1:0] tgt;
        logic          exp_redir;
        logic          drop;
    } vec_t;

    exp_t q[$];
    exp_t mon_act;
    exp_t mon_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                                input logic [RW-1:0] rd, input logic [3:0] ctl,
                                input logic [2:0] br, input logic zero,
                                input logic [DW-1:0] tgt, input logic redir,
                                input logic drop);
        vec_t v;
        v.alu = alu; v.sdata = sd; v.rd = rd; v.ctl = ctl; v.br = br;
        v.zero = zero; v.tgt = tgt; v.exp_redir = redir; v.drop = drop;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.addr = v.alu; e.sdata = v.sdata; e.rd = v.rd; e.ctl = v.ctl;
        return e;
    endfunction

    task automatic apply(input vec_t v);
        alu_out          = v.alu;
        ex_store_data    = v.sdata;
        ex_rd            = v.rd;
        {ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg} = v.ctl;
        {ex_br_uncond, ex_br_zero, ex_br_nzero} = v.br;
        alu_zero         = v.zero;
        ex_branch_target = v.tgt;
    endtask

    // Present one entry, wait (bounded) for ready, hold for the accepting edge.
    task automatic send(input vec_t v, input logic push);
        int t;
        t = 0;
        apply(v);
        ex_valid = 1'b1;
        while (!ex_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ex_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: ex_ready got 0 expected 1 within 50 cycles");
        end
        if (push) q.push_back(to_exp(v));
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Memory-side scoreboard: every entry taken must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && !flush && mem_valid && mem_ready) begin
            mon_act = {mem_addr_result, mem_store_data, mem_rd,
                       mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg};
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_entry: got %0h expected none", mon_act);
            end else begin
                mon_exp = q.pop_front();
                chk("mem_entry", mon_act, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt[10];
    vec_t v30;
    vec_t vz;

    initial begin
        // ctl = {mem_read, mem_write, reg_write, mem_to_reg}; br = {B, CBZ, CBNZ}
        vt[0] = mk(64'h100,  64'h0,    5'd1, 4'b0010, 3'b000, 1'b0, 64'h0,    1'b0, 1'b0);
        vt[1] = mk(64'h0,    64'h0,    5'd0, 4'b0000, 3'b010, 1'b1, 64'h400,  1'b1, 1'b0);
        vt[2] = mk(64'hBAD,  64'h0,    5'd7, 4'b0010, 3'b000, 1'b0, 64'h0,    1'b0, 1'b1);
        vt[3] = mk(64'h0,    64'h0,    5'd0, 4'b0000, 3'b001, 1'b1, 64'h800,  1'b0, 1'b0);
        vt[4] = mk(64'h200,  64'h0,    5'd2, 4'b0010, 3'b000, 1'b1, 64'h0,    1'b0, 1'b0);
        vt[5] = mk(64'h0,    64'h0,    5'd0, 4'b0000, 3'b100, 1'b0, 64'h1000, 1'b1, 1'b0);
        vt[6] = mk(64'h300,  64'h0,    5'd4, 4'b1011, 3'b000, 1'b0, 64'h0,    1'b0, 1'b1);
        vt[7] = mk(64'h0,    64'h0,    5'd0, 4'b0000, 3'b001, 1'b0, 64'h2000, 1'b1, 1'b0);
        vt[8] = mk(64'h40,   64'hDEAD, 5'd0, 4'b0100, 3'b000, 1'b0, 64'h0,    1'b0, 1'b1);
        vt[9] = mk(64'h0,    64'h0,    5'd0, 4'b0000, 3'b010, 1'b0, 64'h3000, 1'b0, 1'b0);
        vz    = mk(64'h0, 64'h0, 5'd0, 4'b0000, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0);

        // ---------------- reset dominance ----------------
        apply(vz);
        flush = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
        ex_valid = 1'b1; alu_out = 64'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_mem_fields", {mem_addr_result, mem_store_data, mem_rd, mem_mem_read,
                               mem_mem_write, mem_reg_write, mem_mem_to_reg}, 0);
        ex_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_mem_valid", mem_valid, 0);

        send(mk(64'h5, 64'h0, 5'd3, 4'b0010, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        chk("first_mem_valid", mem_valid, 1);
        chk("first_addr", mem_addr_result, 64'h5);
        chk("first_rd", mem_rd, 3);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("first_drained", mem_valid, 0);

        // ---------------- back-pressure into skid ----------------
        mem_ready = 1'b0;
        send(mk(64'h10, 64'h1, 5'd10, 4'b0010, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        send(mk(64'h20, 64'h2, 5'd11, 4'b1011, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        chk("bp_ex_ready_two", ex_ready, 0);
        chk("bp_head", mem_addr_result, 64'h10);
        v30 = mk(64'h30, 64'h3, 5'd12, 4'b0100, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0);
        apply(v30);
        ex_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_ready", ex_ready, 0);
            chk("bp_hold_head", mem_addr_result, 64'h10);
        end
        q.push_back(to_exp(v30));
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_skid_to_head", mem_addr_result, 64'h20);
        chk("bp_ready_after_drain", ex_ready, 1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("bp_third_head", mem_addr_result, 64'h30);
        @(posedge clk); #1;
        chk("bp_empty", mem_valid, 0);
        chk("bp_queue_empty", q.size(), 0);

        // ---------------- branch table, back-to-back ----------------
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(vt[i]);
            ex_valid = 1'b1;
            chk("tbl_ex_ready", ex_ready, 1);
            if (!vt[i].drop) q.push_back(to_exp(vt[i]));
            @(posedge clk); #1;
            chk($sformatf("tbl_redirect_valid[%0d]", i), redirect_valid, vt[i].exp_redir);
            if (vt[i].exp_redir) chk($sformatf("tbl_redirect_pc[%0d]", i), redirect_pc, vt[i].tgt);
        end
        ex_valid = 1'b0;
        apply(vz);
        for (int t = 0; t < 20 && q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("tbl_queue_empty", q.size(), 0);
        chk("tbl_redirect_idle", redirect_valid, 0);

        // ---------------- flush while full, taken branch incoming ----------------
        mem_ready = 1'b0;
        send(mk(64'h50, 64'h0, 5'd5, 4'b0010, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        send(mk(64'h60, 64'h0, 5'd6, 4'b1011, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        chk("fl_two", ex_ready, 0);
        apply(mk(64'h70, 64'h0, 5'd0, 4'b0000, 3'b100, 1'b0, 64'h5000, 1'b0, 1'b0));
        ex_valid = 1'b1; flush = 1'b1;
        q.delete();
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0;
        chk("fl_mem_valid", mem_valid, 0);
        chk("fl_ex_ready", ex_ready, 1);
        chk("fl_no_redirect", redirect_valid, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("fl_stays_empty", mem_valid, 0);
        end

        // ---------------- reset while full with mem_ready high ----------------
        mem_ready = 1'b0;
        send(mk(64'h80, 64'h0, 5'd8, 4'b0010, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        send(mk(64'h90, 64'h0, 5'd9, 4'b0010, 3'b000, 1'b0, 64'h0, 1'b0, 1'b0), 1'b1);
        chk("rs_two", ex_ready, 0);
        rst_n = 1'b0; mem_ready = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rs_mem_valid", mem_valid, 0);
        chk("rs_ex_ready", ex_ready, 1);
        chk("rs_mem_ctl", {mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rs_stays_empty", mem_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Registered EX->MEM boundary directly downstream of the 64-bit ALU.
- Captures the ALU result, Zero flag, store data, destination register and memory/writeback controls.
- Resolves B/CBZ/CBNZ into a one-cycle PC redirect.
- Decouples execute from memory with a valid/ready handshake backed by a 2-entry skid buffer, so ex_ready is a pure register output.

Parameters:
DATA_W, 64, width of ALU result, store data, PC and branch target
REG_W, 5, width of destination register index

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  execute slot holds an instruction
ex_ready  out  1  stage can accept this cycle; registered
alu_out  in  DATA_W  ALU result (address or data)
alu_zero  in  1  ALU Zero flag
ex_store_data  in  DATA_W  register data for STUR
ex_branch_target  in  DATA_W  precomputed PC + (offset<<2)
ex_rd  in  REG_W  destination register
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  memory/WB controls
ex_br_uncond, ex_br_zero, ex_br_nzero  in  1 each  B, CBZ, CBNZ
flush  in  1  discard all held and incoming entries
mem_valid  out  1  head entry valid
mem_ready  in  1  memory stage accepts head
mem_addr_result, mem_store_data  out  DATA_W  head fields
mem_rd  out  REG_W  head field
mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  head fields
redirect_valid  out  1  one-cycle taken-branch pulse
redirect_pc  out  DATA_W  target for redirect_valid

Behaviour:
- Reset (rst_n=0 at edge), dominant over all other inputs:
  - mem_valid=0, ex_ready=1, redirect_valid=0, redirect_pc=0.
  - All mem_* data/control outputs = 0.
  - Occupancy = EMPTY.
  - Mid-operation reset drops held entries with no redirect.
- Accept condition: ex_valid & ex_ready. Drain condition: mem_valid & mem_ready.
- Occupancy FSM (head register + skid register):
  - EMPTY: accept -> ONE, entry into head.
  - ONE, accept & drain -> ONE, new entry replaces head.
  - ONE, accept only -> TWO, entry into skid.
  - ONE, drain only -> EMPTY.
  - TWO, drain -> ONE, skid moves to head. ex_ready=0 in TWO, so no accept is possible.
- ex_ready is registered: 1 in EMPTY/ONE, 0 in TWO. It equals next-state != TWO.
- Head outputs are registered. mem_valid = state != EMPTY. Head fields hold stable while mem_valid & !mem_ready.
- Latency: an entry accepted at edge N appears on mem_* after edge N, if the stage was empty or drained that cycle.
- Branch taken = ex_br_uncond | (ex_br_zero & alu_zero) | (ex_br_nzero & !alu_zero). At most one branch control bit is asserted at a time.
- On accept of a taken branch:
  - Next cycle redirect_valid=1 and redirect_pc=ex_branch_target, for exactly one cycle.
  - The branch itself still enters the buffer with reg_write/mem controls as presented. It is normally all-zero for a branch.
- Wrong-path drop: an accept in a cycle where redirect_valid=1 is consumed but not stored. ex_ready is unaffected. Occupancy is unchanged except for any drain.
- Not-taken branch: no redirect; entry stored normally.
- flush=1 at edge:
  - Occupancy -> EMPTY, mem_valid=0, ex_ready=1.
  - An incoming accept that cycle is dropped, and a pending redirect is not generated.
  - redirect_valid already high stays high for its single cycle.
  - Flush has priority over accept and drain. mem_ready that cycle is ignored for bookkeeping, since the entry is discarded.
- Dropped or flushed entries never assert any memory or writeback control on mem_*.
- Fields are stored verbatim; no width conversion or arithmetic besides the taken-branch equation.

Test Plan:
- Reset with ex_valid=1, alu_out=64'h5 -> mem_valid=0, ex_ready=1, redirect_valid=0, all mem_* outputs 0; after release, first accept of alu_out=64'h5, rd=3 gives mem_addr_result=5, mem_rd=3 next cycle.
- Back-to-back accepts 0x10, 0x20, 0x30 with mem_ready=0:
  - State reaches TWO after 0x20; ex_ready=0 and 0x30 is not accepted.
  - Head stays 0x10.
  - Raising mem_ready outputs 0x10, 0x20, 0x30 in order with no loss or duplication.
- CBZ, alu_zero=1, target=64'h400 -> redirect_valid=1 one cycle later with redirect_pc=0x400. An ADD accepted during the pulse never appears on mem_valid. The same test with CBNZ -> no redirect.
- B (uncond) with alu_zero=0, target=64'h1000 -> redirect_pc=0x1000, single-cycle pulse.
- State TWO with flush=1 and ex_valid=1 -> next cycle mem_valid=0, ex_ready=1; neither held entry nor incoming entry emerges later.
- rst_n=0 while in TWO with mem_ready=1 -> no entry drained after reset; mem_valid=0.
